pipe_ctrl: RTL and testbench

//  Central pipeline controller for the 5-stage MIPS core. It arbitrates stall requests

---
 rtl/pipe_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline controller: arbitrates per-stage stall requests, sequences exception/ERET
// entry (freeze, one-cycle flush, redirect), and runs a stall watchdog and stall counter.
module pipe_ctrl #(
  parameter int unsigned STALL_LIMIT = 16,
  parameter logic [31:0] EXC_OFFSET  = 32'h180,
  parameter logic [4:0]  ERET_CODE   = 5'h0E
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic [4:0]  excp_code,
  input  logic [31:0] cp0_ebase,
  input  logic [31:0] cp0_epc,
  input  logic        stall_clr,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        wdog_excp,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);

  localparam int unsigned CntW = $clog2(STALL_LIMIT);
  localparam logic [CntW-1:0] CntLast = CntW'(STALL_LIMIT - 1);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [CntW-1:0] r_wdog_cnt;
  logic [31:0]     r_new_pc;
  logic            r_wdog_excp;
  logic            r_stall_timeout;
  logic [31:0]     r_stall_cycles;

  logic            w_any_req;
  logic            w_in_run;
  logic            w_wdog_hit;
  logic            w_exc_hit;
  logic [5:0]      w_stall;

  assign w_any_req  = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;
  assign w_in_run   = (r_state == StRun);
  assign w_wdog_hit = w_in_run & w_any_req & (r_wdog_cnt == CntLast);
  assign w_exc_hit  = w_in_run & (excp_valid | w_wdog_hit);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic: FLUSH always lasts exactly one cycle
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StRun:   if (w_exc_hit) w_state_d = StFlush;
      StFlush: w_state_d = StRun;
      default: w_state_d = StRun;
    endcase
  end

  // Output logic; stall is forced low while reset is asserted
  always_comb begin
    w_stall = 6'b000000;
    flush   = 1'b0;
    unique case (r_state)
      StRun: begin
        if (w_exc_hit || stallreq_mem) w_stall = 6'b011111;
        else if (stallreq_ex)          w_stall = 6'b001111;
        else if (stallreq_id)          w_stall = 6'b000111;
        else if (stallreq_if)          w_stall = 6'b000011;
      end
      StFlush: flush = 1'b1;
      default: ;
    endcase
    stall = rst_n ? w_stall : 6'b000000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_new_pc        <= 32'h0;
      r_wdog_excp     <= 1'b0;
      r_stall_timeout <= 1'b0;
      r_wdog_cnt      <= '0;
    end else begin
      r_wdog_excp <= w_exc_hit & w_wdog_hit & ~excp_valid;
      if (w_exc_hit) begin
        r_new_pc <= (excp_valid && excp_code == ERET_CODE) ? cp0_epc : cp0_ebase + EXC_OFFSET;
      end
      if (w_wdog_hit) r_stall_timeout <= 1'b1;
      if (!w_in_run || w_wdog_hit || !w_any_req) r_wdog_cnt <= '0;
      else                                       r_wdog_cnt <= r_wdog_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'h0;
    end else if (stall_clr) begin
      r_stall_cycles <= 32'h0;
    end else if (w_stall != 6'b000000 && r_stall_cycles != 32'hFFFF_FFFF) begin
      r_stall_cycles <= r_stall_cycles + 32'h1;
    end
  end

  assign new_pc        = r_new_pc;
  assign wdog_excp     = r_wdog_excp;
  assign stall_timeout = r_stall_timeout;
  assign stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: inputs change on the falling edge, outputs are checked
// 1 time unit later, so each step observes the state left by the preceding rising edge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        excp_valid;
  logic [4:0]  excp_code;
  logic [31:0] cp0_ebase, cp0_epc;
  logic        stall_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        wdog_excp;
  logic        stall_timeout;
  logic [31:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(
    .STALL_LIMIT(16),
    .EXC_OFFSET (32'h180),
    .ERET_CODE  (5'h0E)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excp_valid   (excp_valid),
    .excp_code    (excp_code),
    .cp0_ebase    (cp0_ebase),
    .cp0_epc      (cp0_epc),
    .stall_clr    (stall_clr),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .wdog_excp    (wdog_excp),
    .stall_timeout(stall_timeout),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input logic i_if, input logic i_id, input logic i_ex, input logic i_mem);
    stallreq_if  = i_if;
    stallreq_id  = i_id;
    stallreq_ex  = i_ex;
    stallreq_mem = i_mem;
  endtask

  initial begin
    // T1: reset with random inputs, clock running
    rst_n = 1'b0;
    stall_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_req(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      excp_valid = 1'($urandom);
      excp_code  = 5'($urandom);
      cp0_ebase  = $urandom;
      cp0_epc    = $urandom;
      #1;
      check("rst_stall", 32'(stall), 32'h0);
      check("rst_flush", 32'(flush), 32'h0);
      check("rst_new_pc", new_pc, 32'h0);
      check("rst_cycles", stall_cycles, 32'h0);
    end
    check("rst_wdog_excp", 32'(wdog_excp), 32'h0);
    check("rst_timeout", 32'(stall_timeout), 32'h0);

    @(negedge clk);
    set_req(0, 0, 0, 0);
    excp_valid = 1'b0;
    excp_code  = 5'h00;
    cp0_ebase  = 32'h8000_0000;
    cp0_epc    = 32'h0;
    rst_n      = 1'b1;
    #1;

    // T2: priority (stall_cycles counts each stalled edge)
    set_req(0, 1, 1, 0); #1;
    check("prio_id_ex", 32'(stall), 32'(6'b001111));
    next_cycle();
    set_req(1, 0, 0, 0); #1;
    check("prio_if", 32'(stall), 32'(6'b000011));
    next_cycle();
    set_req(0, 0, 0, 1); #1;
    check("prio_mem", 32'(stall), 32'(6'b011111));
    next_cycle();
    set_req(0, 1, 0, 0); #1;
    check("prio_id", 32'(stall), 32'(6'b000111));
    next_cycle();
    set_req(0, 0, 0, 0); #1;
    check("prio_none", 32'(stall), 32'h0);
    check("cycles_after_prio", stall_cycles, 32'd4);
    next_cycle();

    // T3: general exception
    excp_valid = 1'b1;
    excp_code  = 5'h08; #1;
    check("exc_freeze", 32'(stall), 32'(6'b011111));
    check("exc_no_flush_yet", 32'(flush), 32'h0);
    next_cycle();
    excp_valid = 1'b0; #1;
    check("exc_flush", 32'(flush), 32'h1);
    check("exc_new_pc", new_pc, 32'h8000_0180);
    check("exc_flush_stall", 32'(stall), 32'h0);
    check("exc_wdog_excp", 32'(wdog_excp), 32'h0);
    next_cycle();
    check("exc_flush_done", 32'(flush), 32'h0);
    check("exc_run_stall", 32'(stall), 32'h0);
    check("exc_pc_held", new_pc, 32'h8000_0180);

    // T4: ERET, with a second pulse and stall request during FLUSH ignored
    excp_valid = 1'b1;
    excp_code  = 5'h0E;
    cp0_epc    = 32'h0040_1234; #1;
    check("eret_freeze", 32'(stall), 32'(6'b011111));
    next_cycle();
    stallreq_mem = 1'b1; #1;
    check("eret_flush", 32'(flush), 32'h1);
    check("eret_new_pc", new_pc, 32'h0040_1234);
    check("eret_flush_ignores_req", 32'(stall), 32'h0);
    next_cycle();
    excp_valid   = 1'b0;
    stallreq_mem = 1'b0; #1;
    check("eret_no_second_flush", 32'(flush), 32'h0);
    check("cycles_after_exc", stall_cycles, 32'd6);
    next_cycle();

    // T5: watchdog fires on the 16th consecutive stalled cycle
    stallreq_mem = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      #1;
      if (k == 15) begin
        check("wdog_k15_flush", 32'(flush), 32'h0);
        check("wdog_k15_timeout", 32'(stall_timeout), 32'h0);
      end
      if (k == 16) check("wdog_k16_stall", 32'(stall), 32'(6'b011111));
      next_cycle();
    end
    check("wdog_flush", 32'(flush), 32'h1);
    check("wdog_excp_pulse", 32'(wdog_excp), 32'h1);
    check("wdog_new_pc", new_pc, 32'h8000_0180);
    check("wdog_timeout", 32'(stall_timeout), 32'h1);
    check("wdog_flush_stall", 32'(stall), 32'h0);
    next_cycle();
    stallreq_mem = 1'b0; #1;
    check("wdog_flush_done", 32'(flush), 32'h0);
    check("wdog_excp_clear", 32'(wdog_excp), 32'h0);
    check("wdog_timeout_sticky", 32'(stall_timeout), 32'h1);
    check("cycles_after_wdog", stall_cycles, 32'd22);
    next_cycle();

    // Watchdog coincident with a real exception: real exception wins
    cp0_ebase    = 32'h9000_0000;
    stallreq_mem = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) begin
        excp_valid = 1'b1;
        excp_code  = 5'h04;
      end
      next_cycle();
    end
    excp_valid   = 1'b0;
    stallreq_mem = 1'b0; #1;
    check("coinc_flush", 32'(flush), 32'h1);
    check("coinc_new_pc", new_pc, 32'h9000_0180);
    check("coinc_wdog_excp", 32'(wdog_excp), 32'h0);
    check("coinc_timeout", 32'(stall_timeout), 32'h1);
    next_cycle();

    // T6: counter clear, count, clear alongside a stall, saturation
    stall_clr = 1'b1;
    next_cycle();
    stall_clr = 1'b0; #1;
    check("cnt_cleared", stall_cycles, 32'h0);
    stallreq_if = 1'b1;
    for (int k = 0; k < 10; k++) next_cycle();
    stallreq_if = 1'b0; #1;
    check("cnt_ten", stall_cycles, 32'd10);
    stallreq_if = 1'b1;
    stall_clr   = 1'b1;
    next_cycle();
    stallreq_if = 1'b0;
    stall_clr   = 1'b0; #1;
    check("cnt_clr_wins", stall_cycles, 32'h0);

    force dut.r_stall_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cycles;
    stallreq_if = 1'b1;
    next_cycle();
    check("cnt_reach_max", stall_cycles, 32'hFFFF_FFFF);
    next_cycle();
    next_cycle();
    stallreq_if = 1'b0; #1;
    check("cnt_saturated", stall_cycles, 32'hFFFF_FFFF);
    next_cycle();

    // Reset asserted mid-FLUSH
    excp_valid = 1'b1;
    excp_code  = 5'h08;
    next_cycle();
    excp_valid = 1'b0; #1;
    check("midflush_flush", 32'(flush), 32'h1);
    rst_n = 1'b0; #1;
    check("midflush_async_flush", 32'(flush), 32'h0);
    check("midflush_async_pc", new_pc, 32'h0);
    check("midflush_async_timeout", 32'(stall_timeout), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    stallreq_mem = 1'b1; #1;
    check("post_reset_run_stall", 32'(stall), 32'(6'b011111));
    check("post_reset_flush", 32'(flush), 32'h0);
    next_cycle();
    stallreq_mem = 1'b0; #1;
    check("post_reset_cycles", stall_cycles, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
